// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential RV32M divider: operation codes,
// FSM state encodings and default sizing.
package seq_divider_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Bit 0 clear marks the signed variants, bit 1 set selects the remainder.
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the execute-stage controller (master)
// and the divider (slave).
interface seq_divider_if import seq_divider_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    modport master (output start, op, op1, op2, input busy, done, res);
    modport slave  (input start, op, op1, op2, output busy, done, res);
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left and keep the
// trial subtraction only when it does not go negative.
module seq_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor};
        // The extra top bit is the borrow: set means the divisor did not fit.
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per
// clock, with the RISC-V divide-by-zero and overflow cases resolved in one cycle.
module seq_divider import seq_divider_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] abs1, abs2;
    logic             sgn, accept;

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;

        sgn    = is_signed_op(bus.op);
        abs1   = (sgn && bus.op1[WIDTH-1]) ? -bus.op1 : bus.op1;
        abs2   = (sgn && bus.op2[WIDTH-1]) ? -bus.op2 : bus.op2;
        accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d   = bus.op;
                    negq_d = sgn && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
                    negr_d = sgn && bus.op1[WIDTH-1];
                    rem_d  = '0;
                    quo_d  = abs1;
                    dvs_d  = abs2;
                    // Architecturally defined results bypass the iteration.
                    if (bus.op2 == '0) begin
                        state_d = S_DONE;
                        res_d   = is_rem_op(bus.op) ? bus.op1 : '1;
                    end else if (sgn && bus.op1 == MIN_NEG && bus.op2 == '1) begin
                        state_d = S_DONE;
                        res_d   = is_rem_op(bus.op) ? '0 : MIN_NEG;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = is_rem_op(op_q) ? (negr_q ? -rem_nx : rem_nx)
                                              : (negq_q ? -quo_nx : quo_nx);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy = (state_q == S_CALC);
    assign bus.done = (state_q == S_DONE);
    assign bus.res  = res_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider: results via a scoreboard
// popped on done, plus latency, busy length, protocol and reset behaviour.
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        if (bus.done) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow: done with empty scoreboard, res=%h", bus.res);
            end
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                assert (bus.res === e) else begin
                    errors++;
                    $error("FAIL %s: res=%h expected=%h", t, bus.res, e);
                end
                $display("txn %s res=%h expected=%h", t, bus.res, e);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag,
                          input bit b2b, input int inject_at);
        int cyc;
        int busy_cnt;
        bit seen;
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op1   = a;
        bus.op2   = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op1   = $urandom;
        bus.op2   = $urandom;
        bus.op    = 2'($urandom);
        cyc      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (cyc <= 40) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            bus.start = (cyc == inject_at);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat > 1 ? exp_lat - 1 : 0));
    endtask

    initial begin
        int sa, sb;
        logic [31:0] ua, ub;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.op1   = '0;
        bus.op2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_res", bus.res, 32'd0);
        rst_n = 1'b1;

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7", 1'b0, 0);
        run_op(OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33, "rem_m100_7", 1'b0, 0);
        run_op(OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, "div_m100_7", 1'b0, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "div_by_zero", 1'b0, 0);
        run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero", 1'b0, 0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow", 1'b0, 0);
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_overflow", 1'b0, 0);

        run_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, "start_in_calc", 1'b0, 5);

        run_op(OP_REMU, 32'd1000, 32'd7, 32'd6, 33, "b2b_first", 1'b0, 0);
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "b2b_second", 1'b1, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("res_hold", bus.res, 32'hFFFFFFFD);
        end

        for (int i = 0; i < 4; i++) begin
            ua = $urandom;
            ub = $urandom >> (i * 8);
            if (ub == 0) ub = 32'd3;
            run_op(OP_DIVU, ua, ub, ua / ub, 33, "rand_divu", 1'b0, 0);
            run_op(OP_REMU, ua, ub, ua % ub, 33, "rand_remu", 1'b0, 0);
            sa = $urandom;
            sb = int'($urandom) >>> (i * 8);
            if (sb == 0) sb = -3;
            if (sa == int'(32'h80000000) && sb == -1) sb = 5;
            run_op(OP_DIV, 32'(sa), 32'(sb), 32'(sa / sb), 33, "rand_div", 1'b0, 0);
            run_op(OP_REM, 32'(sa), 32'(sb), 32'(sa % sb), 33, "rand_rem", 1'b0, 0);
        end

        // Abort an operation with reset part-way through the iteration.
        run_op(OP_DIVU, 32'd77, 32'd3, 32'd25, 33, "pre_reset", 1'b0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.op1   = 32'd12345;
        bus.op2   = 32'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_res", bus.res, 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_res_held", bus.res, 32'd0);
        rst_n = 1'b1;
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33, "post_reset", 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
